// File: rtl/converter.sv
// Signed fixed-point mantissa times a power-of-two scale -> IEEE-754 single.
// Multi-cycle: capture, normalise one bit per clock, round (nearest-even), pack.
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous active-high reset
//   fixed    - two's-complement 32-bit mantissa
//   exp_in   - two's-complement power-of-two scale
//   load_new - start strobe; operands sampled on the edge where it is high
//   float    - registered IEEE-754 single result
//   done     - one-cycle pulse in the first cycle float shows a new result
module converter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fixed,
  input  logic [7:0]  exp_in,
  input  logic        load_new,
  output logic [31:0] float,
  output logic        done
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned EXP_W  = 10;
  localparam int unsigned MANT_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    PACK  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic                      sign_q, sign_d;
  logic                      zero_q, zero_d;
  logic [DATA_W-1:0]         mag_q, mag_d;
  logic signed [EXP_W-1:0]   e_q, e_d;
  logic [MANT_W-1:0]         mant_q, mant_d;
  logic [DATA_W-1:0]         float_q, float_d;
  logic                      done_q, done_d;

  logic                      guard_c;
  logic                      sticky_c;
  logic                      round_up_c;
  logic [MANT_W:0]           mant_sum_c;

  // Round-to-nearest-even on the normalised magnitude.
  always_comb begin
    guard_c    = mag_q[7];
    sticky_c   = |mag_q[6:0];
    round_up_c = guard_c & (sticky_c | mag_q[8]);
    mant_sum_c = {1'b0, mag_q[31:8]} + (MANT_W+1)'(round_up_c);
  end

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    mag_d   = mag_q;
    e_d     = e_q;
    mant_d  = mant_q;
    float_d = float_q;
    done_d  = 1'b0;

    // A strobe in any state (re)starts a conversion with fresh operands.
    if (load_new) begin
      sign_d  = fixed[31];
      zero_d  = (fixed == 32'h0);
      mag_d   = fixed[31] ? (~fixed + 32'd1) : fixed;
      e_d     = $signed({{2{exp_in[7]}}, exp_in}) + $signed(10'd158);
      state_d = NORM;
    end else begin
      unique case (state_q)
        IDLE: ;
        NORM: begin
          if (zero_q) begin
            state_d = PACK;
          end else if (mag_q[31]) begin
            state_d = ROUND;
          end else begin
            mag_d = {mag_q[30:0], 1'b0};
            e_d   = e_q - $signed(10'd1);
          end
        end
        ROUND: begin
          if (mant_sum_c[MANT_W]) begin
            mant_d = 24'h800000;
            e_d    = e_q + $signed(10'd1);
          end else begin
            mant_d = mant_sum_c[MANT_W-1:0];
          end
          state_d = PACK;
        end
        PACK: begin
          if (zero_q) begin
            float_d = 32'h0;
          end else if (e_q >= $signed(10'd255)) begin
            float_d = {sign_q, 8'hFF, 23'h0};
          end else if (e_q <= $signed(10'd0)) begin
            float_d = {sign_q, 31'h0};
          end else begin
            float_d = {sign_q, e_q[7:0], mant_q[22:0]};
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      e_q     <= '0;
      mant_q  <= '0;
      float_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      mag_q   <= mag_d;
      e_q     <= e_d;
      mant_q  <= mant_d;
      float_q <= float_d;
      done_q  <= done_d;
    end
  end

  assign float = float_q;
  assign done  = done_q;

endmodule

// File: tb/tb_converter.sv
// Directed bench for converter: hand-computed IEEE-754 results.
module tb_converter;

  logic        clk;
  logic        reset;
  logic [31:0] fixed;
  logic [7:0]  exp_in;
  logic        load_new;
  logic [31:0] float;
  logic        done;

  int total;
  int bad;
  int done_cnt;

  converter dut (
    .clk      (clk),
    .reset    (reset),
    .fixed    (fixed),
    .exp_in   (exp_in),
    .load_new (load_new),
    .float    (float),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      $error("%s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Count done pulses over a fixed window of n cycles.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
  endtask

  // One-cycle strobe, wait 40 clocks, check result and single done pulse.
  task automatic convert(input string tag, input logic [31:0] f, input logic [7:0] e,
                         input logic [31:0] exp_v);
    @(negedge clk);
    fixed    = f;
    exp_in   = e;
    load_new = 1'b1;
    done_cnt = 0;
    @(negedge clk);
    load_new = 1'b0;
    if (done === 1'b1) done_cnt++;
    run_cycles(40);
    check32(tag, float, exp_v);
    check32({tag, "_done"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    done_cnt = 0;
    reset    = 1'b1;
    fixed    = '0;
    exp_in   = '0;
    load_new = 1'b0;
    repeat (3) @(negedge clk);
    check32("reset_float", float, 32'h0);
    check32("reset_done", 32'(done), 32'd0);
    reset = 1'b0;

    convert("one",        32'h00000001, 8'h00, 32'h3F800000);
    convert("two",        32'h00000001, 8'h01, 32'h40000000);
    convert("six_half",   32'h0000000D, 8'hFF, 32'h40D00000);
    convert("neg_one",    32'hFFFFFFFF, 8'h00, 32'hBF800000);
    convert("most_neg",   32'h80000000, 8'h00, 32'hCF000000);
    convert("tie_even",   32'h01000001, 8'h00, 32'h4B800000);
    convert("tie_odd",    32'h01000003, 8'h00, 32'h4B800002);
    convert("carry_out",  32'h01FFFFFF, 8'h00, 32'h4C000000);
    convert("zero",       32'h00000000, 8'h05, 32'h00000000);
    convert("max_exp",    32'h00000001, 8'h7F, 32'h7F000000);
    convert("pos_inf",    32'h7FFFFFFF, 8'h7F, 32'h7F800000);
    convert("neg_inf",    32'h80000001, 8'h7F, 32'hFF800000);
    convert("flush_pos",  32'h00000001, 8'h80, 32'h00000000);
    convert("flush_neg",  32'hFFFFFFFF, 8'h80, 32'h80000000);

    // Latency: fixed=1 needs the longest normalisation; result by 35 clocks.
    @(negedge clk);
    fixed = 32'h00000001; exp_in = 8'h01; load_new = 1'b1; done_cnt = 0;
    @(negedge clk);
    load_new = 1'b0;
    run_cycles(33);
    check32("latency_hold", float, 32'hBF800000 ^ 32'hBF800000 | 32'h80000000);
    run_cycles(2);
    check32("latency_val", float, 32'h40000000);
    check32("latency_done", 32'(done_cnt), 32'd1);

    // Restart mid-conversion: only the second operand set completes.
    @(negedge clk);
    fixed = 32'h00000001; exp_in = 8'h00; load_new = 1'b1; done_cnt = 0;
    @(negedge clk);
    load_new = 1'b0;
    run_cycles(5);
    fixed = 32'h0000000D; exp_in = 8'hFF; load_new = 1'b1;
    @(negedge clk);
    load_new = 1'b0;
    if (done === 1'b1) done_cnt++;
    run_cycles(40);
    check32("restart_val", float, 32'h40D00000);
    check32("restart_done", 32'(done_cnt), 32'd1);

    // Held strobe restarts every cycle; last operands win.
    @(negedge clk);
    fixed = 32'h00000003; exp_in = 8'h00; load_new = 1'b1; done_cnt = 0;
    @(negedge clk);
    fixed = 32'h00000005; exp_in = 8'h00;
    @(negedge clk);
    load_new = 1'b0;
    run_cycles(40);
    check32("held_val", float, 32'h40A00000);
    check32("held_done", 32'(done_cnt), 32'd1);

    // Reset mid-conversion: float cleared, no done.
    @(negedge clk);
    fixed = 32'h00000001; exp_in = 8'h00; load_new = 1'b1; done_cnt = 0;
    @(negedge clk);
    load_new = 1'b0;
    run_cycles(5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check32("rst_mid_float", float, 32'h0);
    run_cycles(40);
    check32("rst_mid_hold", float, 32'h0);
    check32("rst_mid_done", 32'(done_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
